// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment frame decoder: glyph codes,
// FSM states and the glyph-to-nibble decoder.
package seg_pkg;

    localparam logic [6:0] GLYPH_0     = 7'h3F;
    localparam logic [6:0] GLYPH_1     = 7'h06;
    localparam logic [6:0] GLYPH_2     = 7'h5B;
    localparam logic [6:0] GLYPH_3     = 7'h4F;
    localparam logic [6:0] GLYPH_4     = 7'h66;
    localparam logic [6:0] GLYPH_5     = 7'h6D;
    localparam logic [6:0] GLYPH_6     = 7'h7D;
    localparam logic [6:0] GLYPH_7     = 7'h07;
    localparam logic [6:0] GLYPH_8     = 7'h7F;
    localparam logic [6:0] GLYPH_9     = 7'h6F;
    localparam logic [6:0] GLYPH_A     = 7'h77;
    localparam logic [6:0] GLYPH_B     = 7'h7C;
    localparam logic [6:0] GLYPH_C     = 7'h39;
    localparam logic [6:0] GLYPH_D     = 7'h5E;
    localparam logic [6:0] GLYPH_E     = 7'h79;
    localparam logic [6:0] GLYPH_F     = 7'h71;
    localparam logic [6:0] GLYPH_BLANK = 7'h00;

    typedef enum logic {COLLECT, PUBLISH} state_t;

    // Returns {valid, nibble}; a blank digit decodes as a valid zero.
    function automatic logic [4:0] glyph_to_nibble(input logic [6:0] g);
        logic [4:0] r;
        case (g)
            GLYPH_0:     r = {1'b1, 4'h0};
            GLYPH_1:     r = {1'b1, 4'h1};
            GLYPH_2:     r = {1'b1, 4'h2};
            GLYPH_3:     r = {1'b1, 4'h3};
            GLYPH_4:     r = {1'b1, 4'h4};
            GLYPH_5:     r = {1'b1, 4'h5};
            GLYPH_6:     r = {1'b1, 4'h6};
            GLYPH_7:     r = {1'b1, 4'h7};
            GLYPH_8:     r = {1'b1, 4'h8};
            GLYPH_9:     r = {1'b1, 4'h9};
            GLYPH_A:     r = {1'b1, 4'hA};
            GLYPH_B:     r = {1'b1, 4'hB};
            GLYPH_C:     r = {1'b1, 4'hC};
            GLYPH_D:     r = {1'b1, 4'hD};
            GLYPH_E:     r = {1'b1, 4'hE};
            GLYPH_F:     r = {1'b1, 4'hF};
            GLYPH_BLANK: r = {1'b1, 4'h0};
            default:     r = {1'b0, 4'h0};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg_stable_sampler.sv
// Registers the (polarity-corrected) scan inputs and emits one capture strobe
// per stable period once they have held for SETTLE_CYCLES cycles.
module seg_stable_sampler #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk1,
    input  logic       rst_n,
    input  logic [7:0] an,
    input  logic [7:0] seg,
    output logic       cap_stb,
    output logic [7:0] cap_an,
    output logic [7:0] cap_seg
);

    localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

    logic [7:0] s_an;
    logic [7:0] s_seg;
    logic [3:0] cnt;
    logic       same;

    // Comparing the incoming value to the register equals comparing the
    // register's next value with its current one.
    assign same = ({an, seg} == {s_an, s_seg});

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            s_an  <= '0;
            s_seg <= '0;
            cnt   <= '0;
        end else begin
            s_an  <= an;
            s_seg <= seg;
            if (!same)
                cnt <= '0;
            else if (cnt != SETTLE)
                cnt <= cnt + 4'd1;
        end
    end

    // Fires on the edge where cnt reaches SETTLE; saturation keeps it one-shot.
    assign cap_stb = same && (cnt == SETTLE - 4'd1);
    assign cap_an  = s_an;
    assign cap_seg = s_seg;

endmodule

// File: rtl/seg_frame_decoder.sv
// Reconstructs the eight hex digits shown on a multiplexed seven-segment scan
// and publishes them as one frame once every position has been captured.
module seg_frame_decoder
    import seg_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic        clk1,
    input  logic        rst_n,
    input  logic [7:0]  AN,
    input  logic [7:0]  SEG,
    output logic [31:0] frame_value,
    output logic [7:0]  frame_dp,
    output logic        frame_valid,
    output logic        frame_err
);

    logic [7:0]      an_in;
    logic [7:0]      seg_in;
    logic            cap_stb;
    logic [7:0]      cap_an;
    logic [7:0]      cap_seg;
    logic [4:0]      dec;
    logic            an_any;
    logic            an_multi;
    logic [7:0]      cap_mask;
    logic            cap_err;
    logic [7:0][3:0] shadow;
    logic [7:0]      shadow_dp;
    logic [7:0]      seen;
    logic            err_sticky;
    state_t          state;

    assign an_in  = ACTIVE_LOW ? ~AN  : AN;
    assign seg_in = ACTIVE_LOW ? ~SEG : SEG;

    seg_stable_sampler #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_sampler (
        .clk1    (clk1),
        .rst_n   (rst_n),
        .an      (an_in),
        .seg     (seg_in),
        .cap_stb (cap_stb),
        .cap_an  (cap_an),
        .cap_seg (cap_seg)
    );

    assign dec      = glyph_to_nibble(cap_seg[6:0]);
    assign an_any   = |cap_an;
    assign an_multi = |(cap_an & (cap_an - 8'd1));
    assign cap_mask = (cap_stb && an_any && !an_multi) ? cap_an : 8'h00;
    assign cap_err  = cap_stb && (an_multi || (an_any && !dec[4]));

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            shadow    <= '0;
            shadow_dp <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (cap_mask[i]) begin
                    shadow[i]    <= dec[3:0];
                    shadow_dp[i] <= cap_seg[7];
                end
            end
        end
    end

    // A capture on the publishing edge seeds the next frame rather than being lost.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= COLLECT;
            seen        <= '0;
            err_sticky  <= 1'b0;
            frame_value <= '0;
            frame_dp    <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            case (state)
                COLLECT: begin
                    if (seen == 8'hFF) begin
                        frame_value <= shadow;
                        frame_dp    <= shadow_dp;
                        frame_err   <= err_sticky;
                        frame_valid <= 1'b1;
                        seen        <= cap_mask;
                        err_sticky  <= cap_err;
                        state       <= PUBLISH;
                    end else begin
                        seen       <= seen | cap_mask;
                        err_sticky <= err_sticky | cap_err;
                    end
                end
                PUBLISH: begin
                    seen       <= seen | cap_mask;
                    err_sticky <= err_sticky | cap_err;
                    state      <= COLLECT;
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_frame_decoder.sv
// Bench for seg_frame_decoder: table-driven frames, hand-built corner cases and
// a randomized scan, all checked cycle by cycle against a run-length model.
module tb_seg_frame_decoder;

    localparam int S  = 2;
    localparam bit AL = 1'b1;

    logic        clk1 = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  AN = 8'hFF;
    logic [7:0]  SEG = 8'hFF;
    logic [31:0] frame_value;
    logic [7:0]  frame_dp;
    logic        frame_valid;
    logic        frame_err;

    always #5 clk1 = ~clk1;

    seg_frame_decoder #(.SETTLE_CYCLES(S), .ACTIVE_LOW(AL)) dut (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .AN          (AN),
        .SEG         (SEG),
        .frame_value (frame_value),
        .frame_dp    (frame_dp),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    int checks = 0;
    int errors = 0;

    logic [6:0] glyphs [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model: a value is captured when it has been seen at S+1
    // consecutive edges; a full set of digits publishes on the following edge.
    logic [15:0] m_prev;
    int          m_run;
    logic [3:0]  m_nib [8];
    logic [7:0]  m_dp;
    logic [7:0]  m_seen;
    logic        m_err;
    logic        m_pend;
    logic [31:0] e_value;
    logic [7:0]  e_dp;
    logic        e_valid;
    logic        e_err;

    int          pulses = 0;
    logic        got = 1'b0;
    logic [31:0] g_value;
    logic [7:0]  g_dp;
    logic        g_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = '0; m_run = 1; m_dp = '0; m_seen = '0; m_err = 0; m_pend = 0;
        for (int i = 0; i < 8; i++) m_nib[i] = '0;
        e_value = '0; e_dp = '0; e_valid = 0; e_err = 0;
    endtask

    task automatic model_capture(input logic [7:0] an, input logic [7:0] seg);
        int d;
        logic [3:0] nib;
        logic found;
        if ($countones(an) == 0) return;
        if ($countones(an) > 1) begin m_err = 1; return; end
        d = 0;
        for (int i = 0; i < 8; i++) if (an[i]) d = i;
        nib = 0;
        found = (seg[6:0] == 7'h00);
        for (int g = 0; g < 16; g++)
            if (glyphs[g] == seg[6:0]) begin nib = 4'(g); found = 1; end
        if (!found) m_err = 1;
        m_nib[d] = nib; m_dp[d] = seg[7]; m_seen[d] = 1;
    endtask

    task automatic model_edge();
        logic [15:0] v;
        if (!rst_n) begin model_reset(); return; end
        v = AL ? ~{AN, SEG} : {AN, SEG};
        e_valid = 0;
        if (m_pend) begin
            for (int i = 0; i < 8; i++) e_value[4*i +: 4] = m_nib[i];
            e_dp = m_dp; e_err = m_err; e_valid = 1;
            m_seen = 0; m_err = 0; m_pend = 0;
        end
        if (v == m_prev) m_run++; else m_run = 1;
        m_prev = v;
        if (m_run == S + 1) model_capture(v[15:8], v[7:0]);
        if (m_seen == 8'hFF) m_pend = 1;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk1);
            model_edge();
            @(negedge clk1);
            chk("valid", 32'(frame_valid), 32'(e_valid));
            chk("value", frame_value, e_value);
            chk("dp", 32'(frame_dp), 32'(e_dp));
            chk("err", 32'(frame_err), 32'(e_err));
            if (frame_valid) begin
                got = 1; pulses++;
                g_value = frame_value; g_dp = frame_dp; g_err = frame_err;
            end
        end
    endtask

    task automatic show(input logic [7:0] an, input logic [7:0] seg, input int n);
        AN  = AL ? ~an  : an;
        SEG = AL ? ~seg : seg;
        tick(n);
    endtask

    task automatic digit(input int i, input logic [6:0] g, input logic dp, input int n);
        logic [7:0] an;
        an = '0;
        an[i] = 1'b1;
        show(an, {dp, g}, n);
    endtask

    task automatic wait_frame(input string name);
        for (int k = 0; k < 20 && !got; k++) tick(1);
        chk({name, "_pulse"}, 32'(got), 32'd1);
    endtask

    task automatic scan_count(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) digit(i, glyphs[i + 1], 1'b0, 4);
    endtask

    typedef struct packed {
        logic [7:0][6:0] g;
        logic [7:0]      dp;
        logic [31:0]     value;
        logic [7:0]      edp;
        logic            err;
    } vec_t;

    vec_t tbl [4];
    int   p0;

    initial begin
        tbl[0] = '{g: {7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06},
                   dp: 8'h00, value: 32'h8765_4321, edp: 8'h00, err: 1'b0};
        tbl[1] = '{g: {7'h3F, 7'h6F, 7'h49, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71},
                   dp: 8'h00, value: 32'h090B_CDEF, edp: 8'h00, err: 1'b1};
        tbl[2] = '{g: {7'h5B, 7'h4F, 7'h66, 7'h7D, 7'h07, 7'h00, 7'h6D, 7'h77},
                   dp: 8'h00, value: 32'h2346_705A, edp: 8'h00, err: 1'b0};
        tbl[3] = '{g: {8{7'h7F}}, dp: 8'h81, value: 32'h8888_8888, edp: 8'h81, err: 1'b0};

        model_reset();
        tick(2);
        chk("rst_value", frame_value, 32'h0);
        chk("rst_valid", 32'(frame_valid), 32'h0);
        rst_n = 1'b1;
        tick(3);

        for (int t = 0; t < 4; t++) begin
            got = 0; p0 = pulses;
            for (int i = 0; i < 8; i++) digit(i, tbl[t].g[i], tbl[t].dp[i], 4);
            wait_frame("tbl");
            chk("tbl_value", g_value, tbl[t].value);
            chk("tbl_dp", 32'(g_dp), 32'(tbl[t].edp));
            chk("tbl_err", 32'(g_err), 32'(tbl[t].err));
            chk("tbl_npulse", 32'(pulses - p0), 32'd1);
        end

        // Short glitch on digit 3 must not count; a later rescan completes the frame.
        got = 0; p0 = pulses;
        scan_count(0, 2);
        digit(3, 7'h66, 1'b0, 2);
        scan_count(4, 7);
        chk("glitch_nofr", 32'(pulses - p0), 32'd0);
        digit(3, 7'h77, 1'b0, 4);
        wait_frame("glitch");
        chk("glitch_value", g_value, 32'h8765_A321);
        chk("glitch_err", 32'(g_err), 32'd0);

        // Two digit enables at once flag the frame without storing anything.
        got = 0;
        scan_count(0, 3);
        show(8'b0000_0011, {1'b0, 7'h06}, 5);
        scan_count(4, 7);
        wait_frame("multi");
        chk("multi_err", 32'(g_err), 32'd1);
        chk("multi_value", g_value, 32'h8765_4321);

        // Reset mid-frame drops partial digits.
        scan_count(0, 4);
        rst_n = 1'b0;
        tick(1);
        chk("midrst_value", frame_value, 32'h0);
        chk("midrst_dp", 32'(frame_dp), 32'h0);
        chk("midrst_valid", 32'(frame_valid), 32'h0);
        chk("midrst_err", 32'(frame_err), 32'h0);
        rst_n = 1'b1;
        got = 0; p0 = pulses;
        scan_count(5, 7);
        tick(3);
        chk("midrst_nofr", 32'(pulses - p0), 32'd0);
        scan_count(0, 4);
        wait_frame("midrst");
        chk("midrst_frame", g_value, 32'h8765_4321);

        // Randomized scan: digit order, holds, glyphs, blanking and multi-hot.
        for (int n = 0; n < 400; n++) begin
            int r;
            int hold;
            r = $urandom_range(0, 19);
            hold = $urandom_range(1, 6);
            if (r == 0)
                show(8'h00, 8'($urandom), hold);
            else if (r == 1)
                show(8'($urandom) | 8'h18, 8'($urandom), hold);
            else if (r == 2)
                digit($urandom_range(0, 7), 7'($urandom), 1'($urandom), hold);
            else
                digit($urandom_range(0, 7), glyphs[$urandom_range(0, 15)], 1'($urandom), hold);
        end
        show(8'h00, 8'h00, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
